// File: rtl/mac_operand_loader.sv
// Operand loader for the MAC datapath: collects A/B pairs into two banks,
// then replays them in index order with first/last markers and a done pulse.
module mac_operand_loader #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_cnt,
    output logic [DW-1:0] out_a,
    output logic [DW-1:0] out_b,
    output logic          out_first,
    output logic          out_last,
    output logic          done,
    output logic [AW:0]   vec_len
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_PLAY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   len;
    logic          in_fire;
    logic          out_fire;
    logic          at_last;

    logic [DW-1:0] bank_a [DEPTH];
    logic [DW-1:0] bank_b [DEPTH];

    // Handshake qualifiers; in_ready is held low while reset is applied.
    assign in_ready  = (state == S_LOAD) && !reset;
    assign out_valid = (state == S_PLAY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign rd_nxt  = rd_ptr + AW'(1);
    assign at_last = ({1'b0, rd_ptr} == (len - (AW+1)'(1)));

    assign out_cnt   = rd_ptr;
    assign out_first = out_valid && (rd_ptr == '0);
    assign out_last  = out_valid && at_last;
    assign done      = (state == S_DONE);

    // Operand banks: written on input handshakes, never cleared.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            bank_a[wr_ptr] <= in_a;
            bank_b[wr_ptr] <= in_b;
        end
    end

    // Load/replay sequencer with registered bank reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len     <= '0;
            vec_len <= '0;
            out_a   <= '0;
            out_b   <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (in_fire) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        if (in_last || wr_ptr == {AW{1'b1}}) begin
                            len   <= {1'b0, wr_ptr} + (AW+1)'(1);
                            state <= S_PRIME;
                        end
                    end
                end
                S_PRIME: begin
                    out_a  <= bank_a[0];
                    out_b  <= bank_b[0];
                    rd_ptr <= '0;
                    state  <= S_PLAY;
                end
                S_PLAY: begin
                    if (out_fire) begin
                        if (at_last) begin
                            state <= S_DONE;
                        end else begin
                            rd_ptr <= rd_nxt;
                            out_a  <= bank_a[rd_nxt];
                            out_b  <= bank_b[rd_nxt];
                        end
                    end
                end
                S_DONE: begin
                    vec_len <= len;
                    wr_ptr  <= '0;
                    state   <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_loader.sv
// Bench for mac_operand_loader: scoreboard of expected output beats
// filled as pairs are loaded and drained by a negedge monitor.
module tb_mac_operand_loader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_cnt;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic          out_first;
    logic          out_last;
    logic          done;
    logic [AW:0]   vec_len;

    typedef struct {
        logic [AW-1:0] cnt;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          first;
        logic          last;
    } beat_t;

    beat_t q[$];

    int tests = 0;
    int fails = 0;
    int beats = 0;
    int mac_sum = 0;

    mac_operand_loader #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cnt(out_cnt), .out_a(out_a), .out_b(out_b),
        .out_first(out_first), .out_last(out_last),
        .done(done), .vec_len(vec_len)
    );

    always #5 clk = ~clk;

    // Monitor: checks every accepted beat against the scoreboard,
    // stability under stall, and ready/valid exclusivity.
    logic          stall = 1'b0;
    logic [AW-1:0] p_cnt;
    logic [DW-1:0] p_a, p_b;
    logic          p_first, p_last;

    always @(negedge clk) begin
        beat_t e;
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                tests++;
                if (out_valid !== 1'b1 || out_cnt !== p_cnt || out_a !== p_a ||
                    out_b !== p_b || out_first !== p_first || out_last !== p_last) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b cnt=%0d a=%0d b=%0d f=%b l=%b want v=1 cnt=%0d a=%0d b=%0d f=%b l=%b",
                             out_valid, out_cnt, out_a, out_b, out_first, out_last,
                             p_cnt, p_a, p_b, p_first, p_last);
                end
            end
            if (in_ready === 1'b1 && out_valid === 1'b1) begin
                tests++;
                fails++;
                $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 want not both");
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_extra: cnt=%0d a=%0d b=%0d want no beat", out_cnt, out_a, out_b);
                end else begin
                    e = q.pop_front();
                    if (out_cnt !== e.cnt || out_a !== e.a || out_b !== e.b ||
                        out_first !== e.first || out_last !== e.last) begin
                        fails++;
                        $display("FAIL beat: got cnt=%0d a=%0d b=%0d f=%b l=%b want cnt=%0d a=%0d b=%0d f=%b l=%b",
                                 out_cnt, out_a, out_b, out_first, out_last,
                                 e.cnt, e.a, e.b, e.first, e.last);
                    end
                end
                beats++;
                if (out_first) mac_sum = int'(out_a) * int'(out_b);
                else           mac_sum = mac_sum + int'(out_a) * int'(out_b);
            end
            stall   = (out_valid === 1'b1) && (out_ready !== 1'b1);
            p_cnt   = out_cnt;
            p_a     = out_a;
            p_b     = out_b;
            p_first = out_first;
            p_last  = out_last;
        end
    end

    // Drive one pair until accepted; push its expected replay beat.
    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic last, input int idx, input int n);
        beat_t e;
        bit ok = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: idx=%0d in_ready=%b want 1", idx, in_ready);
        end
        e.cnt   = AW'(idx);
        e.a     = a;
        e.b     = b;
        e.first = (idx == 0);
        e.last  = (idx == n - 1);
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for the done pulse within a cycle budget.
    task automatic wait_done(output bit ok);
        ok = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
            vec_len !== '0 || out_cnt !== '0 || out_a !== '0 || out_b !== '0 ||
            out_first !== 1'b0 || out_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b v=%b done=%b len=%0d cnt=%0d a=%0d b=%0d f=%b l=%b want all 0",
                     in_ready, out_valid, done, vec_len, out_cnt, out_a, out_b, out_first, out_last);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_load;
        bit ok;
        beats = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_pair(DW'(i + 1), 8'd2, 1'b0, i, 16);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_prime: rdy=%b v=%b want 0 0", in_ready, out_valid);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_cnt !== 4'd0 || out_a !== 8'd1) begin
            fails++;
            $display("FAIL full_first_latency: v=%b cnt=%0d a=%0d want 1 0 1", out_valid, out_cnt, out_a);
        end
        wait_done(ok);
        tests++;
        if (!ok || beats != 16 || mac_sum != 272) begin
            fails++;
            $display("FAIL full_done: done_seen=%0d beats=%0d sum=%0d want 1 16 272", ok, beats, mac_sum);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || vec_len !== 5'd16 || in_ready !== 1'b1 || q.size() != 0) begin
            fails++;
            $display("FAIL full_after: done=%b len=%0d rdy=%b q=%0d want 0 16 1 0",
                     done, vec_len, in_ready, q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_short;
        bit ok;
        bit rdy_hi = 0;
        beats = 0;
        out_ready = 1'b1;
        send_pair(8'd5, 8'd7, 1'b0, 0, 3);
        send_pair(8'd255, 8'd255, 1'b0, 1, 3);
        send_pair(8'd0, 8'd9, 1'b1, 2, 3);
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) rdy_hi = 1;
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok || beats != 3 || mac_sum != 65060) begin
            fails++;
            $display("FAIL short_done: done_seen=%0d beats=%0d sum=%0d want 1 3 65060", ok, beats, mac_sum);
        end
        tests++;
        if (rdy_hi) begin
            fails++;
            $display("FAIL short_ready_low: in_ready=1 seen want 0 from PRIME to DONE");
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || vec_len !== 5'd3) begin
            fails++;
            $display("FAIL short_len: done=%b len=%0d want 0 3", done, vec_len);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        bit ok;
        beats = 0;
        out_ready = 1'b1;
        send_pair(8'd12, 8'd13, 1'b1, 0, 1);
        wait_done(ok);
        tests++;
        if (!ok || beats != 1 || mac_sum != 156) begin
            fails++;
            $display("FAIL single_done: done_seen=%0d beats=%0d sum=%0d want 1 1 156", ok, beats, mac_sum);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || vec_len !== 5'd1) begin
            fails++;
            $display("FAIL single_len: done=%b len=%0d want 0 1", done, vec_len);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure;
        bit ok;
        bit early = 0;
        logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        beats = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_pair(DW'(8'h20 + i), DW'(3 + i), i == 3, i, 4);
        ok = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_valid_timeout: out_valid=%b want 1", out_valid);
        end
        @(posedge clk);
        for (int k = 0; k < 7; k++) begin
            #1;
            out_ready = pat[k];
            @(negedge clk);
            if (done === 1'b1) early = 1;
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        wait_done(ok);
        tests++;
        if (!ok || early || beats != 4) begin
            fails++;
            $display("FAIL bp_done: done_seen=%0d early=%0d beats=%0d want 1 0 4", ok, early, beats);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || vec_len !== 5'd4 || q.size() != 0) begin
            fails++;
            $display("FAIL bp_len: done=%b len=%0d q=%0d want 0 4 0", done, vec_len, q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_bubbles;
        bit ok;
        beats = 0;
        out_ready = 1'b1;
        send_pair(8'd11, 8'd1, 1'b0, 0, 4);
        in_a = 8'hEE;
        in_b = 8'hEE;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        in_last = 1'b0;
        send_pair(8'd22, 8'd2, 1'b0, 1, 4);
        send_pair(8'd33, 8'd3, 1'b0, 2, 4);
        in_a = 8'hDD;
        in_b = 8'hDD;
        in_last = 1'b1;
        @(posedge clk);
        #1;
        send_pair(8'd44, 8'd4, 1'b1, 3, 4);
        wait_done(ok);
        tests++;
        if (!ok || beats != 4 || mac_sum != 11 + 44 + 99 + 176) begin
            fails++;
            $display("FAIL bubbles_done: done_seen=%0d beats=%0d sum=%0d want 1 4 330", ok, beats, mac_sum);
        end
        @(negedge clk);
        tests++;
        if (vec_len !== 5'd4 || q.size() != 0) begin
            fails++;
            $display("FAIL bubbles_len: len=%0d q=%0d want 4 0", vec_len, q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_play;
        bit ok;
        beats = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send_pair(DW'(100 + i), DW'(i), 1'b0, i, 16);
        ok = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_cnt === 4'd4) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midplay_reach: out_cnt=%0d want 4", out_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || done !== 1'b0 || vec_len !== '0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL midplay_reset: v=%b done=%b len=%0d rdy=%b want 0 0 0 0",
                     out_valid, done, vec_len, in_ready);
        end
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL midplay_release: rdy=%b done=%b want 1 0", in_ready, done);
        end
        @(posedge clk);
        #1;
        beats = 0;
        send_pair(8'd9, 8'd3, 1'b0, 0, 2);
        send_pair(8'd4, 8'd6, 1'b1, 1, 2);
        wait_done(ok);
        tests++;
        if (!ok || beats != 2 || mac_sum != 51) begin
            fails++;
            $display("FAIL midplay_fresh: done_seen=%0d beats=%0d sum=%0d want 1 2 51", ok, beats, mac_sum);
        end
        @(negedge clk);
        tests++;
        if (vec_len !== 5'd2 || q.size() != 0) begin
            fails++;
            $display("FAIL midplay_fresh_len: len=%0d q=%0d want 2 0", vec_len, q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short();
        test_single();
        test_backpressure();
        test_bubbles();
        test_reset_mid_play();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_operand_loader.md
# mac_operand_loader

Write-side companion to the multiply-accumulate datapath. It accepts operand pairs over a valid/ready input stream and stores them in two 16-entry x 8-bit operand banks (A and B). Once a vector is complete, it replays the stored pairs in index order to the MAC over a valid/ready output stream, flagging the first and last elements. It then pulses done and returns to loading. It replaces file-preloaded operand memories with run-time loading and supplies the index sequence that drives the MAC.

## Interface
Parameters:
- DW, 8, operand width
- AW, 4, index width; depth = 2**AW = 16

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input pair valid
- in_ready  out  1  loader can accept a pair
- in_a  in  DW  operand A
- in_b  in  DW  operand B
- in_last  in  1  pair is the final element of the vector
- out_valid  out  1  output pair valid
- out_ready  in  1  MAC accepts the pair
- out_cnt  out  AW  index of the presented pair
- out_a  out  DW  bank A[out_cnt]
- out_b  out  DW  bank B[out_cnt]
- out_first  out  1  first element; MAC clears its accumulator on acceptance
- out_last  out  1  final element
- done  out  1  one-cycle pulse after the last element is accepted
- vec_len  out  AW+1  element count of the last completed vector (1..16)

## Operation
- States: LOAD, PRIME, PLAY, DONE.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid&in_ready) writes bank A[wr_ptr]<=in_a and bank B[wr_ptr]<=in_b, then increments wr_ptr.
  - If the accepted pair has in_last=1 or wr_ptr==15: len<=wr_ptr+1, go to PRIME.
- PRIME (1 cycle):
  - in_ready=0, out_valid=0.
  - Register bank A[0] and bank B[0] into the output registers; rd_ptr<=0.
  - Go to PLAY.
- PLAY:
  - out_valid=1; out_cnt=rd_ptr; out_a/out_b come from registered bank reads.
  - out_first=(rd_ptr==0); out_last=(rd_ptr==len-1).
  - On out_valid&out_ready:
    - If not last: rd_ptr+1, load the next pair.
    - If last: go to DONE.
  - Without out_ready, all out_* hold stable.
- DONE (1 cycle):
  - done=1; vec_len<=len; out_valid=0; wr_ptr<=0.
  - Go to LOAD.
- Single-element vector (in_last on the first pair): len=1, so out_first and out_last are both 1 on the same beat.
- in_a/in_b/in_last are ignored when no handshake occurs. in_valid outside LOAD is not consumed.
- Bank contents are not cleared by reset or by completion. Only entries below len are ever presented.
- Arithmetic: wr_ptr and rd_ptr are AW bits; len and vec_len are AW+1 bits, so 16 is representable. No wrap occurs, because the vector terminates at index 15.

## Timing
- Reset values (cycle after reset sampled high):
  - state=LOAD, wr_ptr=0, rd_ptr=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first cycle after reset deasserts.
  - out_valid=0, out_cnt=0, out_a=0, out_b=0, out_first=0, out_last=0, done=0, vec_len=0.
- Reset mid-LOAD or mid-PLAY:
  - Abort with no done pulse; vec_len is reset to 0.
  - The partial vector is discarded.
- Latency:
  - Handshake of the final input pair at edge N → PRIME in cycle N+1 → out_valid=1 with element 0 in cycle N+2.
  - Last output handshake at edge M → done=1 in cycle M+1 → in_ready=1 in cycle M+2.
- Throughput:
  - One input pair per cycle, and one output pair per cycle with out_ready held high.
  - An L-element vector takes L load cycles + 1 + L + 1 cycles.
- in_ready and out_valid are never high in the same cycle.
- out_valid never drops in PLAY until the last element is accepted. This is AXI-style stability.
- done is a single-cycle pulse, including back-to-back vectors.

## Test plan
- Full load: 16 pairs with A=i+1 and B=2, in_last=0, out_ready=1.
  - Required: out_cnt sequence 0..15 with out_a=1..16, out_b=2; out_first only at 0 and out_last only at 15.
  - Required: done one cycle after, vec_len=16; a downstream MAC model sums to 272.
- Short vector: 3 pairs (5,7), (255,255), (0,9) with in_last on the third.
  - Required: vec_len=3, exactly 3 output beats, MAC sum=65060, in_ready=0 from PRIME through DONE.
- Single element: pair (12,13) with in_last=1.
  - Required: one beat with out_first=out_last=1, out_cnt=0; done follows; vec_len=1.
- Backpressure: 4-pair vector, out_ready toggling 1,0,0,1,0,1,1.
  - Required: outputs stable while stalled; each element is presented exactly once in order; done only after the 4th acceptance.
- Input bubbles: in_valid gapped 1,0,1,1,0,1 with in_last on the 4th accepted pair.
  - Required: wr_ptr advances only on handshakes; 4 elements are replayed.
- Reset mid-PLAY: assert reset during element 5 of a 16-element vector.
  - Required: next cycle out_valid=0, done=0, vec_len=0, in_ready=1 after release.
  - Required: a fresh 2-pair vector then replays correctly.
